uart_cmd_assembler: RTL and testbench

Downstream consumer of the UART receiver.
- Takes its rdy/rx_data byte stream and acknowledges each byte with clr_rdy.
- Packs NUM_BYTES consecutive bytes, MSB-first, into one command word for the LA command dispatcher.
- Presents the word with a cmd_rdy/clr_cmd_rdy handshake and back-pressures the receiver while an unconsumed command is held.

---
 rtl/uart_cmd_pkg.sv | 13 +
 rtl/cmd_gap_timer.sv | 29 ++
 rtl/uart_cmd_assembler.sv | 108 ++++++++++
 tb/tb_uart_cmd_assembler.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and defaults for the UART command assembler.
package uart_cmd_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } asm_state_t;

    localparam int unsigned CLKS_PER_BIT     = 2604;
    localparam int unsigned DEF_NUM_BYTES    = 3;
    localparam int unsigned DEF_TIMEOUT_CLKS = 30 * CLKS_PER_BIT;

endpackage

// File: rtl/cmd_gap_timer.sv
// Inter-byte gap counter: counts while enabled, zeroes on clear or terminal count,
// and flags the cycle in which the count sits at TERMINAL-1.
module cmd_gap_timer #(
    parameter int unsigned TERMINAL = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc_c
);

    localparam int unsigned TW = (TERMINAL > 2) ? $clog2(TERMINAL) : 1;

    logic [TW-1:0] count;

    assign tc_c = enable && !clear && (count == TW'(TERMINAL - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || tc_c) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TW'(1);
        end
    end

endmodule

// File: rtl/uart_cmd_assembler.sv
// Packs NUM_BYTES UART bytes MSB-first into one command word with a cmd_rdy handshake.
// Optional inter-byte timeout is enabled by defining CMD_TIMEOUT_EN.
module uart_cmd_assembler
    import uart_cmd_pkg::*;
#(
    parameter int unsigned NUM_BYTES    = DEF_NUM_BYTES,
    parameter int unsigned TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rdy,
    input  logic [7:0]             rx_data,
    output logic                   clr_rdy,
    input  logic                   clr_cmd_rdy,
    output logic [8*NUM_BYTES-1:0] cmd,
    output logic                   cmd_rdy,
    output logic                   timeout_err
);

    localparam int unsigned CMD_W = 8 * NUM_BYTES;
    localparam int unsigned CNT_W = $clog2(NUM_BYTES + 1);

    if (NUM_BYTES < 2 || NUM_BYTES > 4) begin : g_bad_num_bytes
        $error("uart_cmd_assembler: NUM_BYTES must be 2..4");
    end
    if (TIMEOUT_CLKS < 2) begin : g_bad_timeout
        $error("uart_cmd_assembler: TIMEOUT_CLKS must be at least 2");
    end

    asm_state_t        state, state_d;
    logic [CNT_W-1:0]  byte_cnt, byte_cnt_d;
    logic [CMD_W-1:0]  cmd_d;
    logic              clr_rdy_d, cmd_rdy_d, timeout_err_d;
    logic              capture_c, last_byte_c, gap_tc_c;

    // The ~clr_rdy term skips the cycle where the receiver's rdy is still high after our ack.
    assign capture_c   = rdy && !clr_rdy && (state == COLLECT);
    assign last_byte_c = (byte_cnt == CNT_W'(NUM_BYTES - 1));

`ifdef CMD_TIMEOUT_EN
    cmd_gap_timer #(
        .TERMINAL (TIMEOUT_CLKS)
    ) u_gap_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (capture_c || (state != COLLECT)),
        .enable ((state == COLLECT) && (byte_cnt != '0)),
        .tc_c   (gap_tc_c)
    );
`else
    assign gap_tc_c = 1'b0;
`endif

    // Next-state and next-output decode; capture has priority over timeout.
    always_comb begin
        state_d       = state;
        byte_cnt_d    = byte_cnt;
        cmd_d         = cmd;
        clr_rdy_d     = capture_c;
        cmd_rdy_d     = cmd_rdy;
        timeout_err_d = 1'b0;

        case (state)
            COLLECT: begin
                if (capture_c) begin
                    cmd_d = {cmd[CMD_W-9:0], rx_data};
                    if (last_byte_c) begin
                        byte_cnt_d = '0;
                        cmd_rdy_d  = 1'b1;
                        state_d    = FULL;
                    end else begin
                        byte_cnt_d = byte_cnt + CNT_W'(1);
                    end
                end else if (gap_tc_c) begin
                    byte_cnt_d    = '0;
                    cmd_d         = '0;
                    timeout_err_d = 1'b1;
                end
            end
            FULL: begin
                if (clr_cmd_rdy) begin
                    cmd_rdy_d = 1'b0;
                    state_d   = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= COLLECT;
            byte_cnt    <= '0;
            cmd         <= '0;
            clr_rdy     <= 1'b0;
            cmd_rdy     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            byte_cnt    <= byte_cnt_d;
            cmd         <= cmd_d;
            clr_rdy     <= clr_rdy_d;
            cmd_rdy     <= cmd_rdy_d;
            timeout_err <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Self-checking bench for uart_cmd_assembler: directed cases plus randomized command traffic
// against a byte-history model. Timeout cases follow CMD_TIMEOUT_EN.
module tb_uart_cmd_assembler;

    localparam int unsigned NB = 3;
    localparam int unsigned TO = 100;
    localparam int unsigned W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rdy;
    logic [7:0]   rx_data;
    logic         clr_rdy;
    logic         clr_cmd_rdy;
    logic [W-1:0] cmd;
    logic         cmd_rdy;
    logic         timeout_err;

    int n_vec  = 0;
    int n_err  = 0;
    int pulses = 0;
    int part   = 0;
    logic [7:0] hist[$];

    uart_cmd_assembler #(
        .NUM_BYTES    (NB),
        .TIMEOUT_CLKS (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rdy         (rdy),
        .rx_data     (rx_data),
        .clr_rdy     (clr_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected command word: the last NB captured bytes, oldest in the MS byte, zeros if fewer.
    function automatic logic [W-1:0] exp_cmd();
        logic [W-1:0] r = '0;
        for (int i = 0; i < int'(NB); i++) begin
            int idx = hist.size() - int'(NB) + i;
            logic [7:0] b = (idx >= 0) ? hist[idx] : 8'h00;
            r = {r[W-9:0], b};
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (clr_rdy === 1'b1) pulses++;
    endtask

    // Raise rdy with byte b and wait for the ack; rdy is left high for the caller to drop.
    task automatic ack_byte(input logic [7:0] b, output int waited);
        rdy = 1'b1;
        rx_data = b;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (clr_rdy !== 1'b1 && waited < 40);
        if (clr_rdy !== 1'b1) check_eq("ack_wait", 32'(waited), 32'd1);
        hist.push_back(b);
    endtask

    task automatic release_rdy(input int linger);
        repeat (linger) tick();
        rdy = 1'b0;
        rx_data = 8'($urandom);
    endtask

    // Send one byte with a one-cycle gap and check the model after the ack.
    task automatic send_checked(input logic [7:0] b, input string tag);
        int w;
        tick();
        ack_byte(b, w);
        part++;
        check_eq({tag, "_lat"}, 32'(w), 32'd1);
        check_eq({tag, "_cmd"}, 32'(cmd), 32'(exp_cmd()));
        if (part == int'(NB)) begin
            part = 0;
            check_eq({tag, "_cmdrdy"}, 32'(cmd_rdy), 32'd1);
        end else begin
            check_eq({tag, "_cmdrdy"}, 32'(cmd_rdy), 32'd0);
        end
        check_eq({tag, "_cnt"}, 32'(dut.byte_cnt), 32'(part));
        release_rdy(0);
    endtask

    task automatic clear_cmd();
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        check_eq("clear_cmdrdy", 32'(cmd_rdy), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_clr_rdy"}, 32'(clr_rdy), 32'd0);
        check_eq({tag, "_cmd"}, 32'(cmd), 32'd0);
        check_eq({tag, "_cmd_rdy"}, 32'(cmd_rdy), 32'd0);
        check_eq({tag, "_terr"}, 32'(timeout_err), 32'd0);
        check_eq({tag, "_cnt"}, 32'(dut.byte_cnt), 32'd0);
    endtask

    task automatic mid_reset(input string tag);
        rst_n = 1'b0;
        rdy = 1'b0;
        clr_cmd_rdy = 1'b0;
        #2;
        check_reset_state(tag);
        tick();
        tick();
        rst_n = 1'b1;
        hist.delete();
        part = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0, w, first, cnt;
        logic [7:0] pend_b;
        logic pend;

        rst_n = 1'b0;
        rdy = 1'b0;
        clr_cmd_rdy = 1'b0;
        rx_data = 8'h00;
        repeat (3) tick();
        check_reset_state("reset");
        rst_n = 1'b1;
        tick();

        // Receiver keeps rdy one cycle past the ack: only one capture.
        p0 = pulses;
        ack_byte(8'h7E, w);
        part = 1;
        release_rdy(1);
        tick();
        check_eq("hold_pulses", 32'(pulses - p0), 32'd1);
        check_eq("hold_cnt", 32'(dut.byte_cnt), 32'd1);
        check_eq("hold_cmd", 32'(cmd), 32'(exp_cmd()));

        send_checked(8'($urandom), "pre_rst");
        mid_reset("midrst");

        // Basic three-byte command.
        p0 = pulses;
        send_checked(8'hA5, "b0");
        send_checked(8'h12, "b1");
        send_checked(8'h34, "b2");
        check_eq("t1_pulses", 32'(pulses - p0), 32'd3);
        check_eq("t1_cmd", 32'(cmd), 32'hA51234);

        // Byte offered while FULL waits; clear then capture a cycle later.
        p0 = pulses;
        rdy = 1'b1;
        rx_data = 8'h55;
        repeat (4) tick();
        check_eq("full_noack", 32'(pulses - p0), 32'd0);
        check_eq("full_cmd", 32'(cmd), 32'hA51234);
        check_eq("full_cmdrdy", 32'(cmd_rdy), 32'd1);
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        check_eq("t3_cmdrdy", 32'(cmd_rdy), 32'd0);
        check_eq("t3_noack", 32'(clr_rdy), 32'd0);
        tick();
        check_eq("t3_ack", 32'(clr_rdy), 32'd1);
        hist.push_back(8'h55);
        part = 1;
        check_eq("t3_cmd", 32'(cmd), 32'h123455);
        release_rdy(0);

        // Clear and new byte arrive together in FULL.
        send_checked(8'($urandom), "t4a");
        send_checked(8'($urandom), "t4b");
        pend_b = 8'($urandom);
        clr_cmd_rdy = 1'b1;
        rdy = 1'b1;
        rx_data = pend_b;
        tick();
        clr_cmd_rdy = 1'b0;
        check_eq("t4_cmdrdy", 32'(cmd_rdy), 32'd0);
        check_eq("t4_noack", 32'(clr_rdy), 32'd0);
        tick();
        check_eq("t4_ack", 32'(clr_rdy), 32'd1);
        hist.push_back(pend_b);
        part = 1;
        check_eq("t4_cnt", 32'(dut.byte_cnt), 32'd1);
        release_rdy(0);

        // Inter-byte gap of TO clocks.
        mid_reset("to_rst");
        tick();
        ack_byte(8'h01, w);
        part = 1;
        release_rdy(0);
        first = -1;
        cnt = 0;
        for (int i = 1; i <= 150; i++) begin
            tick();
            if (timeout_err === 1'b1) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
`ifdef CMD_TIMEOUT_EN
        check_eq("to_pulses", 32'(cnt), 32'd1);
        check_eq("to_when", 32'(first), 32'(TO));
        check_eq("to_cnt", 32'(dut.byte_cnt), 32'd0);
        check_eq("to_cmd", 32'(cmd), 32'd0);
        hist.delete();
        part = 0;
        send_checked(8'h02, "to_b0");
        send_checked(8'h03, "to_b1");
        send_checked(8'h04, "to_b2");
        check_eq("to_final", 32'(cmd), 32'h020304);
`else
        check_eq("noto_pulses", 32'(cnt), 32'd0);
        check_eq("noto_cnt", 32'(dut.byte_cnt), 32'd1);
        send_checked(8'h02, "noto_b1");
        send_checked(8'h03, "noto_b2");
        check_eq("noto_final", 32'(cmd), 32'h010203);
`endif
        clear_cmd();

        // Reset partway through a command, then a clean command.
        send_checked(8'($urandom), "r_b0");
        send_checked(8'($urandom), "r_b1");
        mid_reset("r_mid");
        send_checked(8'h0A, "r_c0");
        send_checked(8'h0B, "r_c1");
        send_checked(8'h0C, "r_c2");
        check_eq("t6_cmd", 32'(cmd), 32'h0A0B0C);
        clear_cmd();

        // Randomized traffic: gaps, late rdy drop, held clear, bytes pending while FULL.
        pend = 1'b0;
        pend_b = 8'h00;
        for (int c = 0; c < 30; c++) begin
            logic hold_clr;
            int linger;
            hold_clr = ($urandom_range(0, 3) == 0);
            clr_cmd_rdy = hold_clr;
            for (int k = 0; k < int'(NB); k++) begin
                logic [7:0] b;
                if (k == 0 && pend) begin
                    b = pend_b;
                    pend = 1'b0;
                end else begin
                    b = 8'($urandom);
                    repeat ($urandom_range(0, 3)) tick();
                end
                ack_byte(b, w);
                part++;
                check_eq("rnd_cmd", 32'(cmd), 32'(exp_cmd()));
                if (part == int'(NB)) begin
                    part = 0;
                    check_eq("rnd_cmdrdy_set", 32'(cmd_rdy), 32'd1);
                end else begin
                    check_eq("rnd_cmdrdy_low", 32'(cmd_rdy), 32'd0);
                end
                check_eq("rnd_cnt", 32'(dut.byte_cnt), 32'(part));
                linger = int'($urandom_range(0, 1));
                release_rdy(linger);
                if (k == int'(NB) - 1 && hold_clr) begin
                    if (linger == 0) tick();
                    check_eq("rnd_heldclr", 32'(cmd_rdy), 32'd0);
                    clr_cmd_rdy = 1'b0;
                end
            end
            if (!hold_clr) begin
                pend = 1'($urandom);
                if (pend) begin
                    pend_b = 8'($urandom);
                    rdy = 1'b1;
                    rx_data = pend_b;
                end
                tick();
                repeat ($urandom_range(0, 4)) begin
                    check_eq("rnd_full_noack", 32'(clr_rdy), 32'd0);
                    check_eq("rnd_full_cmd", 32'(cmd), 32'(exp_cmd()));
                    check_eq("rnd_full_rdy", 32'(cmd_rdy), 32'd1);
                    tick();
                end
                clear_cmd();
                check_eq("rnd_clr_noack", 32'(clr_rdy), 32'd0);
            end
        end
        release_rdy(0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
